// File: rtl/turf_regbus_pkg.sv
// Shared widths and FSM state type for the TURF register-core bus arbiter.
package turf_regbus_pkg;

  localparam int REG_ADR_W = 28;
  localparam int REG_DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/turf_register_arbiter_if.sv
// Bundled requester-side and register-core-side signals of the arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's.
interface turf_register_arbiter_if
  import turf_regbus_pkg::*;
#(
  parameter int N_MASTERS = 2
) ();

  logic [N_MASTERS-1:0]           m_en_i;
  logic [N_MASTERS-1:0]           m_wr_i;
  logic [N_MASTERS*REG_ADR_W-1:0] m_adr_i;
  logic [N_MASTERS*REG_DAT_W-1:0] m_dat_i;
  logic [N_MASTERS-1:0]           m_ack_o;
  logic [N_MASTERS-1:0]           m_err_o;
  logic [REG_DAT_W-1:0]           m_dat_o;
  logic                           s_en_o;
  logic                           s_wr_o;
  logic [REG_ADR_W-1:0]           s_adr_o;
  logic [REG_DAT_W-1:0]           s_dat_o;
  logic                           s_ack_i;
  logic [REG_DAT_W-1:0]           s_dat_i;

  modport master (
    input  m_en_i, m_wr_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_en_o, s_wr_o, s_adr_o, s_dat_o
  );

  modport slave (
    output m_en_i, m_wr_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_en_o, s_wr_o, s_adr_o, s_dat_o
  );

endinterface

// File: rtl/turf_register_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod N).
module turf_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turf_register_arbiter.sv
// Round-robin arbiter sharing one TURF register-core bus between N_MASTERS requesters,
// with a single transaction in flight and a timeout that forces an error completion.
module turf_register_arbiter
  import turf_regbus_pkg::*;
#(
  parameter int                   N_MASTERS    = 2,
  parameter int                   TIMEOUT      = 255,
  parameter logic [REG_DAT_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  turf_register_arbiter_if.master bus,
  output logic                    busy_o,
  output logic [15:0]             timeout_cnt_o
);

  localparam int          IDX_W     = $clog2(N_MASTERS);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       ptr, arb_idx;
  logic [N_MASTERS-1:0]   arb_gnt, gnt_oh;
  logic                   arb_valid;
  logic                   s_wr, err;
  logic [REG_ADR_W-1:0]   s_adr, sel_adr;
  logic [REG_DAT_W-1:0]   s_dat, sel_dat, rdat;
  logic                   sel_wr;
  logic [15:0]            wait_cnt, timeout_cnt;

  turf_rr_arbiter #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (bus.m_en_i),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // One-hot grant selects the winning master's request fields.
  always_comb begin
    sel_wr  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (arb_gnt[k]) begin
        sel_wr  = bus.m_wr_i[k];
        sel_adr = bus.m_adr_i[k*REG_ADR_W +: REG_ADR_W];
        sel_dat = bus.m_dat_i[k*REG_DAT_W +: REG_DAT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = bus.s_ack_i ? RESP : WAIT;
      WAIT:    if (bus.s_ack_i || wait_cnt == WAIT_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.s_en_o  = (state == ISSUE);
    bus.m_ack_o = (state == RESP) ? gnt_oh : '0;
    bus.m_err_o = (state == RESP && err) ? gnt_oh : '0;
    busy_o      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= IDX_W'(N_MASTERS - 1);
      gnt_oh      <= '0;
      s_wr        <= 1'b0;
      s_adr       <= '0;
      s_dat       <= '0;
      rdat        <= '0;
      err         <= 1'b0;
      wait_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (arb_valid) begin
          ptr    <= arb_idx;
          gnt_oh <= arb_gnt;
          s_wr   <= sel_wr;
          s_adr  <= sel_adr;
          s_dat  <= sel_dat;
          err    <= 1'b0;
        end
        ISSUE: begin
          if (bus.s_ack_i) rdat     <= bus.s_dat_i;
          else             wait_cnt <= '0;
        end
        WAIT: begin
          if (bus.s_ack_i) begin
            rdat <= bus.s_dat_i;
          end else if (wait_cnt == WAIT_LAST) begin
            rdat <= TIMEOUT_DATA;
            err  <= 1'b1;
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_wr_o    = s_wr;
  assign bus.s_adr_o   = s_adr;
  assign bus.s_dat_o   = s_dat;
  assign bus.m_dat_o   = rdat;
  assign timeout_cnt_o = timeout_cnt;

endmodule

// File: tb/tb_turf_register_arbiter.sv
// Directed self-checking bench for turf_register_arbiter with a small register-core slave model.
module tb_turf_register_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] tcnt;
  int          errors = 0;
  int          checks = 0;

  // Slave model controls: 0 = ack one cycle after strobe, 1 = same cycle, 2 = never.
  int          mode = 0;
  int          inject_at = -1;
  int          cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] mem [16] = '{default: '0};

  turf_register_arbiter_if #(.N_MASTERS(N)) bus ();

  turf_register_arbiter #(
    .N_MASTERS    (N),
    .TIMEOUT      (TO),
    .TIMEOUT_DATA (32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.master),
    .busy_o        (busy),
    .timeout_cnt_o (tcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h0;
    if ((mode == 0 && pend) || (mode == 1 && bus.s_en_o) || cyc == inject_at) begin
      bus.s_ack_i = 1'b1;
      if (bus.s_wr_o) mem[bus.s_adr_o[3:0]] = bus.s_dat_o;
      bus.s_dat_i = mem[bus.s_adr_o[3:0]];
    end
    pend = (mode == 0) && bus.s_en_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Raises one master's request in an IDLE cycle (cycle 0) and follows it to its ack.
  task automatic do_txn(input int m, input logic wr, input logic [27:0] adr, input logic [31:0] dat,
                        output int strobe_c, output int nstrobe, output int ack_c,
                        output logic [1:0] ackv, output logic [1:0] errv,
                        output logic [31:0] rdat, output logic [27:0] sadr);
    @(negedge clk);
    bus.m_en_i[m] = 1'b1;
    bus.m_wr_i[m] = wr;
    bus.m_adr_i[m*28 +: 28] = adr;
    bus.m_dat_i[m*32 +: 32] = dat;
    strobe_c = -1; nstrobe = 0; ack_c = -1; ackv = '0; errv = '0; rdat = '0; sadr = '0;
    for (int c = 1; c <= 40 && ack_c < 0; c++) begin
      @(negedge clk);
      if (bus.s_en_o) begin
        nstrobe++;
        if (strobe_c < 0) begin strobe_c = c; sadr = bus.s_adr_o; end
      end
      if (bus.m_ack_o != '0) begin
        ack_c = c; ackv = bus.m_ack_o; errv = bus.m_err_o; rdat = bus.m_dat_o;
        bus.m_en_i[m] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || bus.s_en_o !== 1'b0 || bus.s_wr_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b s_en=%b s_wr=%b expected 0 0 0", busy, bus.s_en_o, bus.s_wr_o);
    end
    checks++;
    if (bus.s_adr_o !== '0 || bus.s_dat_o !== '0 || bus.m_dat_o !== '0) begin
      errors++; $display("FAIL reset_data: s_adr=%h s_dat=%h m_dat=%h expected 0", bus.s_adr_o, bus.s_dat_o, bus.m_dat_o);
    end
    checks++;
    if (bus.m_ack_o !== '0 || bus.m_err_o !== '0 || tcnt !== 16'h0) begin
      errors++; $display("FAIL reset_ack: m_ack=%b m_err=%b tcnt=%h expected 0", bus.m_ack_o, bus.m_err_o, tcnt);
    end
  endtask

  task automatic test_write_read();
    int sc, ns, ac; logic [1:0] av, ev; logic [31:0] rd; logic [27:0] sa;
    mode = 0;
    do_txn(0, 1'b1, 28'd2, 32'hA5A5_0001, sc, ns, ac, av, ev, rd, sa);
    checks++;
    if (sc !== 1 || ns !== 1) begin
      errors++; $display("FAIL wr_strobe: cycle=%0d count=%0d expected cycle 1 count 1", sc, ns);
    end
    checks++;
    if (ac !== 3 || av !== 2'b01 || ev !== 2'b00) begin
      errors++; $display("FAIL wr_ack: cycle=%0d ack=%b err=%b expected 3 01 00", ac, av, ev);
    end
    checks++;
    if (sa !== 28'd2) begin
      errors++; $display("FAIL wr_adr: s_adr=%h expected 2", sa);
    end
    do_txn(0, 1'b0, 28'd2, 32'h0, sc, ns, ac, av, ev, rd, sa);
    checks++;
    if (ac !== 3 || rd !== 32'hA5A5_0001) begin
      errors++; $display("FAIL rd_back: cycle=%0d m_dat=%h expected 3 a5a50001", ac, rd);
    end
  endtask

  task automatic test_zero_latency();
    int sc, ns, ac; logic [1:0] av, ev; logic [31:0] rd; logic [27:0] sa;
    mode = 1;
    do_txn(1, 1'b1, 28'd7, 32'h1234_5678, sc, ns, ac, av, ev, rd, sa);
    checks++;
    if (sc !== 1 || ac !== 2 || av !== 2'b10) begin
      errors++; $display("FAIL zl_write: strobe=%0d ack_cycle=%0d ack=%b expected 1 2 10", sc, ac, av);
    end
    do_txn(1, 1'b0, 28'd7, 32'h0, sc, ns, ac, av, ev, rd, sa);
    checks++;
    if (ac !== 2 || rd !== 32'h1234_5678 || ev !== 2'b00) begin
      errors++; $display("FAIL zl_read: ack_cycle=%0d m_dat=%h err=%b expected 2 12345678 00", ac, rd, ev);
    end
    mode = 0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] ack_seq [4]; int ack_cyc [4]; logic [27:0] adr_seq [4];
    int n = 0; int ns = 0;
    mode = 0;
    @(negedge clk);
    bus.m_wr_i = 2'b11;
    bus.m_adr_i = {28'd5, 28'd4};
    bus.m_dat_i = {32'h0000_0B0B, 32'h0000_0A0A};
    bus.m_en_i = 2'b11;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.s_en_o && ns < 4) begin adr_seq[ns] = bus.s_adr_o; ns++; end
      if (bus.m_ack_o != '0) begin
        ack_seq[n] = bus.m_ack_o; ack_cyc[n] = c; n++;
        if (n == 4) bus.m_en_i = 2'b00;
      end
    end
    checks++;
    if (n !== 4 || ns !== 4) begin
      errors++; $display("FAIL rr_count: acks=%0d strobes=%0d expected 4 4", n, ns);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_seq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || ack_cyc[i] !== 3 + 4 * i
            || adr_seq[i] !== ((i % 2 == 0) ? 28'd4 : 28'd5)) begin
          errors++;
          $display("FAIL rr_grant%0d: ack=%b cycle=%0d adr=%h expected %b %0d %h", i, ack_seq[i], ack_cyc[i],
                   adr_seq[i], (i % 2 == 0) ? 2'b01 : 2'b10, 3 + 4 * i, (i % 2 == 0) ? 28'd4 : 28'd5);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int sc, ns, ac, bad; logic [1:0] av, ev; logic [31:0] rd; logic [27:0] sa;
    mode = 2;
    do_txn(0, 1'b0, 28'd3, 32'h0, sc, ns, ac, av, ev, rd, sa);
    checks++;
    if (sc !== 1 || ac !== 18 || av !== 2'b01 || ev !== 2'b01) begin
      errors++; $display("FAIL to_ack: strobe=%0d ack_cycle=%0d ack=%b err=%b expected 1 18 01 01", sc, ac, av, ev);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || tcnt !== 16'd1) begin
      errors++; $display("FAIL to_data: m_dat=%h tcnt=%0d expected deadbeef 1", rd, tcnt);
    end
    inject_at = cyc + 3;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || bus.m_ack_o !== '0) bad++;
    end
    inject_at = -1;
    checks++;
    if (bad !== 0 || bus.m_dat_o !== 32'hDEADBEEF || tcnt !== 16'd1) begin
      errors++; $display("FAIL late_ack: disturbances=%0d m_dat=%h tcnt=%0d expected 0 deadbeef 1", bad, bus.m_dat_o, tcnt);
    end
    mode = 0;
    do_txn(1, 1'b1, 28'd6, 32'hCAFE_0006, sc, ns, ac, av, ev, rd, sa);
    checks++;
    if (ac !== 3 || av !== 2'b10 || ev !== 2'b00) begin
      errors++; $display("FAIL post_to_wr: ack_cycle=%0d ack=%b err=%b expected 3 10 00", ac, av, ev);
    end
    do_txn(0, 1'b0, 28'd6, 32'h0, sc, ns, ac, av, ev, rd, sa);
    checks++;
    if (rd !== 32'hCAFE_0006 || ev !== 2'b00) begin
      errors++; $display("FAIL post_to_rd: m_dat=%h err=%b expected cafe0006 00", rd, ev);
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad = 0; int got = 0; logic [1:0] first_ack = '0;
    mode = 2;
    @(negedge clk);
    bus.m_wr_i[0] = 1'b1;
    bus.m_adr_i[27:0] = 28'd9;
    bus.m_dat_i[31:0] = 32'h0000_0001;
    bus.m_en_i[0] = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.s_adr_o !== 28'd9) begin
      errors++; $display("FAIL rst_pre: busy=%b s_adr=%h expected 1 9", busy, bus.s_adr_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.s_wr_o !== 1'b0 || bus.s_adr_o !== '0 || bus.s_dat_o !== '0
        || bus.m_dat_o !== '0 || tcnt !== 16'h0) begin
      errors++;
      $display("FAIL rst_async: busy=%b s_wr=%b s_adr=%h s_dat=%h m_dat=%h tcnt=%h expected all 0",
               busy, bus.s_wr_o, bus.s_adr_o, bus.s_dat_o, bus.m_dat_o, tcnt);
    end
    bus.m_en_i = 2'b00;
    repeat (3) begin
      @(negedge clk);
      if (bus.m_ack_o !== '0 || busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    mode = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.m_ack_o !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL rst_no_ack: spurious=%0d expected 0", bad);
    end
    bus.m_wr_i = 2'b00;
    bus.m_en_i = 2'b11;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(negedge clk);
      if (bus.m_ack_o != '0) begin got = 1; first_ack = bus.m_ack_o; bus.m_en_i = 2'b00; end
    end
    checks++;
    if (first_ack !== 2'b01) begin
      errors++; $display("FAIL rst_priority: first ack=%b expected 01", first_ack);
    end
  endtask

  task automatic test_master_drop();
    int nack = 0; int ac = -1; logic [1:0] av = '0, ev = '0; logic busy_after = 1'b1; logic [27:0] held = '0;
    mode = 2;
    @(negedge clk);
    bus.m_wr_i[1] = 1'b0;
    bus.m_adr_i[55:28] = 28'd8;
    bus.m_en_i[1] = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 3) begin bus.m_en_i[1] = 1'b0; bus.m_adr_i[55:28] = 28'hFFF_FFFF; end
      if (c == 4) held = bus.s_adr_o;
      if (bus.m_ack_o != '0) begin nack++; ac = c; av = bus.m_ack_o; ev = bus.m_err_o; end
      if (c == 19) busy_after = busy;
    end
    checks++;
    if (held !== 28'd8) begin
      errors++; $display("FAIL drop_adr_held: s_adr=%h expected 8", held);
    end
    checks++;
    if (nack !== 1 || ac !== 18 || av !== 2'b10 || ev !== 2'b10) begin
      errors++; $display("FAIL drop_ack: pulses=%0d cycle=%0d ack=%b err=%b expected 1 18 10 10", nack, ac, av, ev);
    end
    checks++;
    if (busy_after !== 1'b0 || tcnt !== 16'd1) begin
      errors++; $display("FAIL drop_idle: busy=%b tcnt=%0d expected 0 1", busy_after, tcnt);
    end
    mode = 0;
  endtask

  initial begin
    bus.m_en_i  = '0;
    bus.m_wr_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_write_read();
    test_zero_latency();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_master_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turf_register_arbiter.md
Name: turf_register_arbiter

Overview:
- Shares one TURF register-core bus (en/wr/ack/adr/dat) between N_MASTERS requesters, for example the host/PCIe control path and the UDP control path.
- Arbitration is round-robin with one transaction in flight.
- Converts the master request into a single-cycle slave strobe and holds address and data stable until the slave acks.
- A bus timeout guarantees every master request terminates.

Parameters:
- N_MASTERS, 2, number of requesters (2..8).
- TIMEOUT, 255, cycles in WAIT without s_ack_i before an error ack is generated (1..65535).
- TIMEOUT_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- m_en_i  in  N_MASTERS  per-master request, held until that master's ack.
- m_wr_i  in  N_MASTERS  1 = write, 0 = read.
- m_adr_i  in  N_MASTERS*28  per-master address, packed with master k at [28k+27:28k].
- m_dat_i  in  N_MASTERS*32  per-master write data, packed.
- m_ack_o  out  N_MASTERS  one-cycle completion pulse to the granted master.
- m_err_o  out  N_MASTERS  qualifies m_ack_o; 1 = timeout.
- m_dat_o  out  32  read data, valid while any m_ack_o bit is high.
- s_en_o  out  1  single-cycle slave strobe.
- s_wr_o  out  1  slave write enable.
- s_adr_o  out  28  slave address.
- s_dat_o  out  32  slave write data.
- s_ack_i  in  1  slave ack.
- s_dat_i  in  32  slave read data, sampled in the cycle s_ack_i is high.
- busy_o  out  1  high in any state other than IDLE.
- timeout_cnt_o  out  16  saturating count of timeouts.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - The round-robin pointer is set to N_MASTERS-1, so master 0 has first priority.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any m_en_i bit is high, grant the first requester at or after pointer+1 (mod N_MASTERS).
  - Register that master's wr, adr and dat into s_wr_o, s_adr_o and s_dat_o.
  - Update the pointer to the grant and go to ISSUE.
- ISSUE:
  - s_en_o = 1 for exactly this cycle.
  - If s_ack_i is also high this cycle, capture s_dat_i and go to RESP; otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - s_en_o = 0; s_wr_o, s_adr_o and s_dat_o are held.
  - On s_ack_i, capture s_dat_i and go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1, load TIMEOUT_DATA, set the error flag, increment timeout_cnt_o (saturating at 16'hFFFF) and go to RESP.
- RESP:
  - The granted master gets m_ack_o = 1 for one cycle; m_dat_o and m_err_o are valid in the same cycle.
  - Next state is IDLE.
  - m_dat_o holds its last value afterwards; it is don't-care when no ack is high.
- Latency against a slave that acks the cycle after the strobe: master request high in cycle 0 (IDLE), s_en_o in cycle 1, s_ack_i in cycle 2, m_ack_o in cycle 3. Minimum request-to-request period is 4 cycles.
- Back-to-back requests: a master that keeps m_en_i high after its ack is treated as a new request in the following IDLE cycle. Round-robin still applies, so with all masters requesting, grants rotate 0,1,..,N-1,0.
- Master drops m_en_i mid-transaction: the transaction completes and the ack pulse is still delivered.
- s_ack_i in IDLE or RESP (late ack after a timeout): ignored, with no state or data change.
- m_adr_i/m_dat_i changes after grant: no effect, because the slave side uses the registered copies.
- Reset asserted mid-transaction: the transaction is abandoned and no ack is delivered. The slave may still have performed the write.

Decomposition:
- Package turf_regbus_pkg holds:
  - REG_ADR_W = 28, REG_DAT_W = 32;
  - the state enum (IDLE, ISSUE, WAIT, RESP) as a 2-bit typedef.
- Sub-module turf_rr_arbiter(N):
  - combinational;
  - inputs: req vector and pointer;
  - output: one-hot grant plus index.
- Counter, capture registers and FSM stay in the top module.

Test Plan:
- Write, m0: adr=2, dat=32'hA5A5_0001, slave acks 1 cycle after strobe -> s_en_o high exactly in cycle 1; m_ack_o[0] in cycle 3 with m_err_o=0; a following read of adr 2 returns 32'hA5A5_0001.
- Simultaneous requests: m0 and m1 raise en in the same cycle and hold it for 4 transactions -> grants m0,m1,m0,m1; each ack goes only to its own master.
- Timeout: TIMEOUT=16, slave never acks -> m_ack_o 17 cycles after the strobe with m_err_o=1, m_dat_o=32'hDEADBEEF, timeout_cnt_o=1. A late s_ack_i 3 cycles later is ignored and the next transaction is unaffected.
- Zero-latency slave: s_ack_i in the same cycle as s_en_o with s_dat_i=32'h1234_5678 -> m_ack_o in the next cycle (cycle 2) with m_dat_o=32'h1234_5678.
- Reset mid-WAIT: rst_n pulsed low in WAIT -> all outputs 0 immediately with no clock edge; no ack is delivered; after release, m0 has priority.
- Master drop: m1 deasserts en in WAIT -> m_ack_o[1] still pulses once and the FSM returns to IDLE.
